// File: rtl/seq_branch_comparator.sv
// seq_branch_comparator
// ---------------------
// Multi-cycle branch comparator. Compares two WIDTH-bit operands CHUNK bits
// per clock, most significant chunk first. It produces eq, signed lt and
// unsigned ltu flags, plus a branch-taken bit y selected by a funct3-style
// mode.
//
// Handshake (valid/ready):
//   start_i is the request valid. It is accepted only when the block is
//   ready, that is in IDLE or DONE. a_i, b_i and mode_i are captured on the
//   accepting edge. busy_o is high while the compare runs. done_o pulses for
//   one cycle when y/eq/lt/ltu become valid. A start while busy is dropped.
//
// Ports:
//   clk_i    clock, rising edge
//   rst_i    synchronous active-high reset
//   start_i  request
//   a_i      operand A
//   b_i      operand B
//   mode_i   branch condition (000 eq, 001 ne, 100 lt, 101 ge, 110 ltu,
//            111 geu, 01x never taken)
//   busy_o   compare in progress
//   done_o   one-cycle result-valid pulse
//   y_o      branch taken
//   eq_o     a == b
//   lt_o     a < b, signed
//   ltu_o    a < b, unsigned
//   state_o  FSM state for debug (0 IDLE, 1 RUN, 2 DONE)
//
// Build option:
//   SEQ_CMP_EARLY_EXIT_EN  when defined, RUN ends on the first differing
//                          chunk. When undefined, the latency is always
//                          NCHUNK+1.
module seq_branch_comparator #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [2:0]       mode_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             y_o,
  output logic             eq_o,
  output logic             lt_o,
  output logic             ltu_o,
  output logic [1:0]       state_o
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CHUNK-1:0] MSB_FLIP = CHUNK'(1) << (CHUNK - 1);

  generate
    if ((CHUNK <= 0) || (WIDTH % CHUNK != 0)) begin : g_bad_chunk
      $error("seq_branch_comparator: WIDTH must be a multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [2:0]       mode_q, mode_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             decided_q, decided_d;
  logic             lt_dec_q, lt_dec_d, ltu_dec_q, ltu_dec_d;
  logic             y_q, y_d, eq_q, eq_d, lt_q, lt_d, ltu_q, ltu_d;

  // Operands are shifted left each RUN cycle, so the chunk under test is
  // always the top CHUNK bits of the latched registers.
  logic [CHUNK-1:0] chunk_a, chunk_b;
  logic             chunk_diff, chunk_ltu, chunk_lt;
  logic             new_decision, last_chunk, finish;
  logic             fin_decided, fin_lt, fin_ltu;

  function automatic logic decode_y(input logic [2:0] m, input logic e,
                                    input logic l, input logic lu);
    logic r;
    case (m)
      3'b000:  r = e;
      3'b001:  r = !e;
      3'b100:  r = l;
      3'b101:  r = !l;
      3'b110:  r = lu;
      3'b111:  r = !lu;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  always_comb begin
    chunk_a      = a_q[WIDTH-1 -: CHUNK];
    chunk_b      = b_q[WIDTH-1 -: CHUNK];
    chunk_diff   = (chunk_a != chunk_b);
    chunk_ltu    = (chunk_a < chunk_b);
    // Only the most significant chunk carries the sign bit. Flipping it on
    // both sides turns the unsigned compare into a two's-complement compare.
    chunk_lt     = (idx_q == '0) ? ((chunk_a ^ MSB_FLIP) < (chunk_b ^ MSB_FLIP))
                                 : chunk_ltu;
    new_decision = !decided_q && chunk_diff;
    last_chunk   = (idx_q == IDXW'(NCHUNK - 1));
    fin_decided  = decided_q || chunk_diff;
    fin_lt       = new_decision ? chunk_lt  : lt_dec_q;
    fin_ltu      = new_decision ? chunk_ltu : ltu_dec_q;
`ifdef SEQ_CMP_EARLY_EXIT_EN
    finish       = last_chunk || new_decision;
`else
    finish       = last_chunk;
`endif
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      mode_q    <= '0;
      idx_q     <= '0;
      decided_q <= 1'b0;
      lt_dec_q  <= 1'b0;
      ltu_dec_q <= 1'b0;
      y_q       <= 1'b0;
      eq_q      <= 1'b0;
      lt_q      <= 1'b0;
      ltu_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      mode_q    <= mode_d;
      idx_q     <= idx_d;
      decided_q <= decided_d;
      lt_dec_q  <= lt_dec_d;
      ltu_dec_q <= ltu_dec_d;
      y_q       <= y_d;
      eq_q      <= eq_d;
      lt_q      <= lt_d;
      ltu_q     <= ltu_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_i) state_d = S_RUN;
      S_RUN:   if (finish)  state_d = S_DONE;
      S_DONE:  state_d = start_i ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values
  always_comb begin
    a_d       = a_q;
    b_d       = b_q;
    mode_d    = mode_q;
    idx_d     = idx_q;
    decided_d = decided_q;
    lt_dec_d  = lt_dec_q;
    ltu_dec_d = ltu_dec_q;
    y_d       = y_q;
    eq_d      = eq_q;
    lt_d      = lt_q;
    ltu_d     = ltu_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          a_d       = a_i;
          b_d       = b_i;
          mode_d    = mode_i;
          idx_d     = '0;
          decided_d = 1'b0;
          lt_dec_d  = 1'b0;
          ltu_dec_d = 1'b0;
        end
      end
      S_RUN: begin
        a_d   = a_q << CHUNK;
        b_d   = b_q << CHUNK;
        idx_d = idx_q + IDXW'(1);
        if (new_decision) begin
          decided_d = 1'b1;
          lt_dec_d  = chunk_lt;
          ltu_dec_d = chunk_ltu;
        end
        if (finish) begin
          eq_d  = !fin_decided;
          lt_d  = fin_decided && fin_lt;
          ltu_d = fin_decided && fin_ltu;
          y_d   = decode_y(mode_q, !fin_decided, fin_decided && fin_lt,
                           fin_decided && fin_ltu);
        end
      end
      default: ;
    endcase
  end

  // Outputs
  always_comb begin
    busy_o  = (state_q == S_RUN);
    done_o  = (state_q == S_DONE);
    state_o = state_q;
    y_o     = y_q;
    eq_o    = eq_q;
    lt_o    = lt_q;
    ltu_o   = ltu_q;
  end

endmodule

// File: tb/tb_seq_branch_comparator.sv
module tb_seq_branch_comparator;

  localparam int W = 32;
  localparam int C = 8;
  localparam int NCH = W / C;
  localparam int TIMEOUT = 20;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic [2:0]   mode = '0;
  logic         busy, done, y, eq, lt, ltu;
  logic [1:0]   state;

  seq_branch_comparator #(.WIDTH(W), .CHUNK(C)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .a_i(a), .b_i(b),
    .mode_i(mode), .busy_o(busy), .done_o(done), .y_o(y), .eq_o(eq),
    .lt_o(lt), .ltu_o(ltu), .state_o(state)
  );

  // Scoreboard: {y, eq, lt, ltu} and expected latency per accepted start
  logic [3:0] exp_q[$];
  int         lat_q[$];
  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int t_acc    = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [3:0] model(input logic [W-1:0] ma,
                                       input logic [W-1:0] mb,
                                       input logic [2:0] mm);
    logic e, l, lu, yy;
    e  = (ma == mb);
    l  = ($signed(ma) < $signed(mb));
    lu = (ma < mb);
    case (mm)
      3'b000:  yy = e;
      3'b001:  yy = !e;
      3'b100:  yy = l;
      3'b101:  yy = !l;
      3'b110:  yy = lu;
      3'b111:  yy = !lu;
      default: yy = 1'b0;
    endcase
    return {yy, e, l, lu};
  endfunction

  function automatic int model_lat(input logic [W-1:0] ma,
                                   input logic [W-1:0] mb);
    int lat;
    lat = NCH + 1;
`ifdef SEQ_CMP_EARLY_EXIT_EN
    for (int k = NCH - 1; k >= 0; k--) begin
      if (ma[W-1-k*C -: C] != mb[W-1-k*C -: C]) lat = k + 2;
    end
`endif
    return lat;
  endfunction

  // Driver: present a request, let it be accepted on the next edge
  task automatic start_op(input logic [W-1:0] oa, input logic [W-1:0] ob,
                          input logic [2:0] om, input bit push);
    a = oa; b = ob; mode = om; start = 1'b1;
    if (push) begin
      exp_q.push_back(model(oa, ob, om));
      lat_q.push_back(model_lat(oa, ob));
    end
    tick();
    t_acc = cyc;
    start = 1'b0;
    // Scramble inputs: the latched copies must be the ones compared
    a = $urandom; b = $urandom; mode = 3'($urandom_range(0, 7));
    check("busy_after_accept", 32'(busy), 32'd1);
  endtask

  // Wait for done, then pop the scoreboard and compare
  task automatic wait_done(input string tag);
    logic [3:0] e;
    int         el;
    while (!done && (cyc - t_acc) < TIMEOUT) begin
      if (cyc != t_acc) check({tag, "_busy"}, 32'(busy), 32'd1);
      tick();
    end
    check({tag, "_timeout"}, 32'(done), 32'd1);
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd1);
    end else begin
      e  = exp_q.pop_front();
      el = lat_q.pop_front();
      check({tag, "_lat"}, 32'(cyc - t_acc + 1), 32'(el));
      check({tag, "_res"}, {28'd0, y, eq, lt, ltu}, {28'd0, e});
      check({tag, "_busy_done"}, 32'(busy), 32'd0);
    end
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic [2:0]   modes[6];
    modes = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111};

    // Reset held two cycles with start asserted
    rst = 1'b1; start = 1'b1; a = 32'h1; b = 32'h2; mode = 3'b001;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_state", 32'(state), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_res", {28'd0, y, eq, lt, ltu}, 32'd0);
    end
    rst = 1'b0; start = 1'b0;
    tick();
    check("post_rst_idle", 32'(state), 32'd0);

    // Equality
    start_op(32'h0000_0015, 32'h0000_0015, 3'b000, 1'b1);
    wait_done("eq_beq");
    tick();
    check("done_one_cycle", 32'(done), 32'd0);
    start_op(32'h0000_0015, 32'h0000_0015, 3'b001, 1'b1);
    wait_done("eq_bne");
    tick();

    // Signed vs unsigned
    start_op(32'hFFFF_FFFF, 32'h0000_0001, 3'b100, 1'b1);
    wait_done("su_blt");
    start_op(32'hFFFF_FFFF, 32'h0000_0001, 3'b110, 1'b1);
    wait_done("su_bltu");
    start_op(32'hFFFF_FFFF, 32'h0000_0001, 3'b111, 1'b1);
    wait_done("su_bgeu");
    start_op(32'hFFFF_FFFF, 32'h0000_0001, 3'b010, 1'b1);
    wait_done("su_mode010");
    tick();

    // Difference in the top chunk (early exit when enabled)
    start_op(32'h1200_0000, 32'h1300_0000, 3'b110, 1'b1);
    wait_done("early");
    tick();

    // Handshake: start during RUN is dropped, start in DONE is taken
    start_op(32'd5, 32'd7, 3'b100, 1'b1);
    tick();
    a = 32'd9; b = 32'd1; mode = 3'b100; start = 1'b1;
    tick();
    start = 1'b0;
    check("ignored_start_busy", 32'(busy), 32'd1);
    wait_done("hs_first");
    start_op(32'h1234_5678, 32'h1234_5678, 3'b000, 1'b1);
    wait_done("hs_b2b");

    // Reset in the middle of a compare
    start_op(32'd1, 32'd2, 3'b110, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_state", 32'(state), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_res", {28'd0, y, eq, lt, ltu}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      check("midrst_no_done", 32'(done), 32'd0);
      tick();
    end

    // Random operands differing in one random chunk, random branch mode
    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = ra;
      if ($urandom_range(0, 3) != 0)
        rb = ra ^ (W'($urandom_range(1, 255)) << (C * $urandom_range(0, NCH - 1)));
      start_op(ra, rb, modes[$urandom_range(0, 5)], 1'b1);
      wait_done("rand");
      if ($urandom_range(0, 1) == 1) tick();
    end

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
